// File: rtl/sram_stream_fifo_ctrl_pkg.sv
// Shared definitions for SRAM-backed streaming stages.
// - DATA_W_DEF / ADDR_W_DEF : default word and address widths of the SRAM macro
// - SKID_DEPTH              : output skid depth that hides the macro's read latency
// - depth_of()              : number of SRAM entries for a given address width
package sram_stream_fifo_ctrl_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int SKID_DEPTH = 2;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/sram_stream_fifo_ctrl_skid.sv
// Two-entry output skid buffer. Slot 0 is the head of the queue.
// Ports:
//   clock, reset  single clock, synchronous active-high reset (clears count only)
//   push          capture push_data this cycle
//   push_data     word to capture
//   pop           remove the head this cycle (only meaningful when count != 0)
//   head          slot 0; holds its last value when the buffer is empty
//   count         number of valid entries, 0..2
module stream_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic [1:0]        kept;

    // occupancy once this cycle's pop has been taken out
    assign kept = count - {1'b0, pop};
    assign head = slot0;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= kept + {1'b0, push};
        end
    end

    // Data slots are not reset: out_bits only has to hold its last value while empty.
    always_ff @(posedge clock) begin
        if (pop && count == 2'd2) begin
            slot0 <= slot1;
        end
        if (push) begin
            if (kept == 2'd0) begin
                slot0 <= push_data;
            end else begin
                slot1 <= push_data;
            end
        end
    end

endmodule

// File: rtl/sram_stream_fifo_ctrl.sv
// Streaming FIFO controller mastering a 1W/1R SRAM macro with 1-cycle read latency.
// Reads are prefetched into a 2-entry skid buffer so the consumer sees a plain
// ready/valid stream at one word per cycle.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   in_valid/in_ready/in_bits    write-side stream
//   out_valid/out_ready/out_bits read-side stream (out_bits = skid head)
//   count                        total occupancy: SRAM + in-flight read + skid
//   W0_addr/W0_en/W0_data        SRAM write port
//   R0_addr/R0_en/R0_data        SRAM read port; R0_data valid the cycle after R0_en
module sram_stream_fifo_ctrl
    import sram_stream_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_bits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_bits,
    output logic [ADDR_W+1:0] count,
    output logic [ADDR_W-1:0] W0_addr,
    output logic              W0_en,
    output logic [DATA_W-1:0] W0_data,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_en,
    input  logic [DATA_W-1:0] R0_data
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(depth_of(ADDR_W));

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_count;
    logic              inflight;
    logic [1:0]        skid_count;
    logic              pop;
    logic [2:0]        skid_claim;

    assign in_ready  = (mem_count != DEPTH_CNT);
    assign W0_en     = in_valid & in_ready;
    assign W0_addr   = wr_ptr;
    assign W0_data   = in_bits;

    assign out_valid = (skid_count != 2'd0);
    assign pop       = out_valid & out_ready;

    // Skid slots already spoken for after this cycle's pop. mem_count only counts
    // writes from earlier cycles, so a read can never target this cycle's write address.
    assign skid_claim = 3'(skid_count) + 3'(inflight) - 3'(pop);
    assign R0_en      = (mem_count != '0) && (skid_claim < 3'(SKID_DEPTH));
    assign R0_addr    = rd_ptr;

    assign count = (ADDR_W + 2)'(mem_count) + (ADDR_W + 2)'(inflight)
                 + (ADDR_W + 2)'(skid_count);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
        end else begin
            if (W0_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (R0_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({W0_en, R0_en})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
            inflight <= R0_en;
        end
    end

    // A read issued just before reset is dropped because inflight clears with it.
    stream_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (R0_data),
        .pop       (pop),
        .head      (out_bits),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_sram_stream_fifo_ctrl.sv
module tb_sram_stream_fifo_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_bits;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_bits;
    logic [AW+1:0] count;
    logic [AW-1:0] W0_addr;
    logic          W0_en;
    logic [DW-1:0] W0_data;
    logic [AW-1:0] R0_addr;
    logic          R0_en;
    logic [DW-1:0] R0_data;

    sram_stream_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .count     (count),
        .W0_addr   (W0_addr),
        .W0_en     (W0_en),
        .W0_data   (W0_data),
        .R0_addr   (R0_addr),
        .R0_en     (R0_en),
        .R0_data   (R0_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural 1W/1R macro, registered read, X on same-address read/write
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (W0_en) mem[W0_addr] <= W0_data;
        if (R0_en) R0_data <= (W0_en && W0_addr == R0_addr) ? 'x : mem[R0_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: FIFO as queues ----------------
    logic [DW-1:0] sram_q[$];
    logic [DW-1:0] skid_q[$];
    bit            m_infl;
    logic [DW-1:0] m_infl_data;
    int            m_wr, m_rd;
    bit            e_in_ready, e_w_en, e_ov, e_pop, e_r_en;
    int            e_count;

    always @(posedge clock) begin
        if (reset) begin
            sram_q.delete();
            skid_q.delete();
            m_infl = 1'b0;
            m_wr   = 0;
            m_rd   = 0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            e_in_ready = sram_q.size() != DEPTH;
            e_w_en     = in_valid && e_in_ready;
            e_ov       = skid_q.size() != 0;
            e_pop      = e_ov && out_ready;
            e_r_en     = sram_q.size() != 0 &&
                         (skid_q.size() + int'(m_infl) - int'(e_pop) < 2);
            e_count    = sram_q.size() + int'(m_infl) + skid_q.size();

            check("m_in_ready", in_ready, e_in_ready);
            check("m_out_valid", out_valid, e_ov);
            check("m_w0_en", W0_en, e_w_en);
            check("m_r0_en", R0_en, e_r_en);
            check("m_count", count, e_count);
            if (e_ov) check("m_out_bits", out_bits, skid_q[0]);
            if (e_w_en) begin
                check("m_w0_addr", W0_addr, m_wr);
                check("m_w0_data", W0_data, in_bits);
            end
            if (e_r_en) check("m_r0_addr", R0_addr, m_rd);
            if (W0_en && R0_en) check("collision", W0_addr == R0_addr, 0);

            if (e_pop) void'(skid_q.pop_front());
            if (m_infl) skid_q.push_back(m_infl_data);
            m_infl = e_r_en;
            if (e_r_en) begin
                m_infl_data = sram_q.pop_front();
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (e_w_en) begin
                sram_q.push_back(in_bits);
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus + literal expectations ----------------
    int  acc, popped, sent, got, gaps, budget;
    bit  refused, started, hit;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_bits = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_w0_en", W0_en, 0);
        check("rst_r0_en", R0_en, 0);
        next_cycle();

        // single word
        in_valid = 1'b1; in_bits = 32'hDEADBEEF; out_ready = 1'b1;
        @(negedge clock);
        check("sw_w0_en", W0_en, 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clock);
        check("sw_r0_en", R0_en, 1);
        check("sw_ov_c1", out_valid, 0);
        next_cycle();
        @(negedge clock);
        check("sw_ov_c2", out_valid, 0);
        check("sw_count_c2", count, 1);
        next_cycle();
        @(negedge clock);
        check("sw_ov_c3", out_valid, 1);
        check("sw_bits", out_bits, 32'hDEADBEEF);
        next_cycle();
        @(negedge clock);
        check("sw_count_end", count, 0);
        check("sw_ov_end", out_valid, 0);
        next_cycle();

        // fill with no consumer
        out_ready = 1'b0; acc = 0; refused = 1'b0;
        for (int i = 0; i < 260; i++) begin
            in_valid = 1'b1; in_bits = acc;
            @(negedge clock);
            if (refused) check("fill_stays_full", in_ready, 0);
            if (in_ready) acc++;
            else refused = 1'b1;
            next_cycle();
        end
        in_valid = 1'b0;
        check("fill_accepted", acc, 258);
        @(negedge clock);
        check("fill_count", count, 258);
        check("fill_in_ready", in_ready, 0);
        next_cycle();

        // full and pop in the same cycle
        out_ready = 1'b1;
        @(negedge clock);
        check("fp_r0_en", R0_en, 1);
        check("fp_in_ready_now", in_ready, 0);
        check("fp_head", out_bits, 0);
        next_cycle();
        out_ready = 1'b0;
        @(negedge clock);
        check("fp_in_ready_next", in_ready, 1);
        check("fp_count", count, 257);
        next_cycle();

        // drain as an in-order ramp
        out_ready = 1'b1; popped = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (out_valid) begin
                check("drain_ramp", out_bits, popped);
                popped++;
            end
            next_cycle();
        end
        check("drain_total", popped, 258);

        // continuous stream across pointer wrap
        sent = 0; got = 0; gaps = 0; started = 1'b0; budget = 0;
        while (got < 1000 && budget < 1200) begin
            in_valid = (sent < 1000); in_bits = 32'h1000_0000 + sent; out_ready = 1'b1;
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                check("wrap_data", out_bits, 32'h1000_0000 + got);
                got++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            next_cycle();
            budget++;
        end
        in_valid = 1'b0;
        check("wrap_words", got, 1000);
        check("wrap_gaps", gaps, 0);

        // random backpressure
        sent = 0; got = 0; budget = 0;
        while (got < 10000 && budget < 40000) begin
            in_valid  = ($urandom_range(0, 99) < 70) && (sent < 10000);
            in_bits   = 32'h2000_0000 + sent;
            out_ready = $urandom_range(0, 1);
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check("bp_data", out_bits, 32'h2000_0000 + got);
                got++;
            end
            next_cycle();
            budget++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_words", got, 10000);

        // reset while a read is in flight and the skid holds data
        hit = 1'b0; budget = 0;
        while (!hit && budget < 50) begin
            in_valid = 1'b1; in_bits = 32'h3000_0000 + budget; out_ready = 1'b0;
            @(negedge clock);
            #1;
            hit = m_infl && skid_q.size() >= 1;
            next_cycle();
            budget++;
        end
        check("mid_reached", hit, 1);
        in_valid = 1'b0; reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("mid_out_valid", out_valid, 0);
        check("mid_count", count, 0);
        check("mid_in_ready", in_ready, 1);
        next_cycle();
        in_valid = 1'b1; in_bits = 32'h1;
        next_cycle();
        in_bits = 32'h2;
        next_cycle();
        in_valid = 1'b0; out_ready = 1'b1; popped = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (out_valid) begin
                if (popped < 2) check("mid_data", out_bits, popped + 1);
                popped++;
            end
            next_cycle();
        end
        check("mid_pops", popped, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
